// File: rtl/plot_sink.sv
// rtl/plot_sink.sv - buffered pixel-plot sink with framebuffer fill engine.
// Optional macro PLOT_BOUNDS_CHECK_EN discards off-screen plots and counts them in drop_count.
module plot_sink #(
   parameter int FIFO_DEPTH = 4,
   parameter int SCREEN_W   = 320,
   parameter int SCREEN_H   = 240
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        plot,
   input  logic [8:0]  X,
   input  logic [7:0]  Y,
   input  logic [2:0]  color,
   input  logic        clear_req,
   input  logic [2:0]  clear_color,
   output logic        fb_we,
   output logic [16:0] fb_addr,
   output logic [2:0]  fb_data,
   output logic        clear_busy,
   output logic        clear_done,
   output logic        frame_done,
   output logic        overflow,
   output logic [7:0]  drop_count
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [16:0] LAST_ADDR = 17'(SCREEN_W * SCREEN_H - 1);

   typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_CLEAR} state_t;

   state_t         r_state;
   logic [19:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0]  r_wr_ptr;
   logic [AW-1:0]  r_rd_ptr;
   logic [CW-1:0]  r_count;
   logic           r_fb_we;
   logic [16:0]    r_fb_addr;
   logic [2:0]     r_fb_data;
   logic           r_clear_busy;
   logic           r_clr_last;
   logic           r_clear_done;
   logic           r_frame_done;
   logic           r_overflow;
   logic [16:0]    r_clr_addr;
   logic [2:0]     r_clr_color;
   logic [7:0]     r_drop_count;

   logic           w_full;
   logic           w_pop;
   logic           w_push;
   logic [CW-1:0]  w_count_next;
   logic           w_clr_end;
   state_t         w_rest_state;
   logic [8:0]     w_hx;
   logic [7:0]     w_hy;
   logic [2:0]     w_hc;
   logic [16:0]    w_addr;
   logic           w_in_range;

   // State DRAIN always means a non-empty FIFO, so it doubles as the pop strobe.
   assign w_full       = (r_count == CW'(FIFO_DEPTH));
   assign w_pop        = (r_state == S_DRAIN);
   assign w_push       = plot && (!w_full || w_pop);
   assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);
   assign w_clr_end    = (r_state == S_CLEAR) && (r_clr_addr == LAST_ADDR);
   assign w_rest_state = (w_count_next != '0) ? S_DRAIN : S_IDLE;

   assign w_hx   = r_mem[r_rd_ptr][19:11];
   assign w_hy   = r_mem[r_rd_ptr][10:3];
   assign w_hc   = r_mem[r_rd_ptr][2:0];
   assign w_addr = {1'b0, w_hy, 8'd0} + {3'd0, w_hy, 6'd0} + {8'd0, w_hx};

`ifdef PLOT_BOUNDS_CHECK_EN
   assign w_in_range = (32'(w_hx) < SCREEN_W) && (32'(w_hy) < SCREEN_H);
`else
   assign w_in_range = 1'b1;
`endif

   always_ff @(posedge clock) begin
      if (!reset && w_push) begin
         r_mem[r_wr_ptr] <= {X, Y, color};
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_fb_we      <= 1'b0;
         r_fb_addr    <= '0;
         r_fb_data    <= '0;
         r_clear_busy <= 1'b0;
         r_clr_last   <= 1'b0;
         r_clear_done <= 1'b0;
         r_frame_done <= 1'b0;
         r_overflow   <= 1'b0;
         r_clr_addr   <= '0;
         r_clr_color  <= '0;
         r_drop_count <= '0;
      end else begin
         r_fb_we      <= 1'b0;
         r_frame_done <= 1'b0;
         r_clr_last   <= w_clr_end;
         r_clear_done <= r_clr_last;
         r_count      <= w_count_next;
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         if (plot && !w_push) begin
            r_overflow <= 1'b1;
         end
         case (r_state)
            S_CLEAR: begin
               r_fb_we    <= 1'b1;
               r_fb_addr  <= r_clr_addr;
               r_fb_data  <= r_clr_color;
               r_clr_addr <= r_clr_addr + 17'd1;
               if (w_clr_end) begin
                  r_state      <= w_rest_state;
                  r_clear_busy <= 1'b0;
               end
            end
            default: begin
               if (w_pop) begin
                  r_fb_we      <= w_in_range;
                  r_fb_addr    <= w_addr;
                  r_fb_data    <= w_hc;
                  r_frame_done <= w_in_range && (w_addr == LAST_ADDR);
`ifdef PLOT_BOUNDS_CHECK_EN
                  if (!w_in_range && (r_drop_count != 8'hFF)) begin
                     r_drop_count <= r_drop_count + 8'd1;
                  end
`endif
               end
               if (clear_req) begin
                  r_state      <= S_CLEAR;
                  r_clear_busy <= 1'b1;
                  r_clr_addr   <= '0;
                  r_clr_color  <= clear_color;
               end else begin
                  r_state <= w_rest_state;
               end
            end
         endcase
      end
   end

   assign fb_we      = r_fb_we;
   assign fb_addr    = r_fb_addr;
   assign fb_data    = r_fb_data;
   assign clear_busy = r_clear_busy;
   assign clear_done = r_clear_done;
   assign frame_done = r_frame_done;
   assign overflow   = r_overflow;
   assign drop_count = r_drop_count;

endmodule

// File: tb/tb_plot_sink.sv
// tb/tb_plot_sink.sv - directed self-checking bench for plot_sink.
module tb_plot_sink;

   logic        clk = 1'b0;
   logic        rst;
   logic        plot;
   logic [8:0]  x;
   logic [7:0]  y;
   logic [2:0]  color;
   logic        clear_req;
   logic [2:0]  clear_color;
   logic        fb_we;
   logic [16:0] fb_addr;
   logic [2:0]  fb_data;
   logic        clear_busy;
   logic        clear_done;
   logic        frame_done;
   logic        overflow;
   logic [7:0]  drop_count;

   always #5 clk = ~clk;

   plot_sink #(.FIFO_DEPTH(4), .SCREEN_W(320), .SCREEN_H(240)) dut (
      .clock(clk), .reset(rst), .plot(plot), .X(x), .Y(y), .color(color),
      .clear_req(clear_req), .clear_color(clear_color),
      .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
      .clear_busy(clear_busy), .clear_done(clear_done), .frame_done(frame_done),
      .overflow(overflow), .drop_count(drop_count)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   logic [19:0] q_wr [$];
   int n_busy = 0;
   int n_done = 0;
   int n_frame = 0;
   int n_frame_bad = 0;

   always @(negedge clk) begin
      if (fb_we) q_wr.push_back({fb_addr, fb_data});
      if (clear_busy) n_busy++;
      if (clear_done) n_done++;
      if (frame_done) n_frame++;
      if (frame_done && !fb_we) n_frame_bad++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_plot(input logic [8:0] px, input logic [7:0] py, input logic [2:0] pc);
      plot = 1'b1; x = px; y = py; color = pc;
      tick();
      plot = 1'b0;
   endtask

   int base_wr, base_busy, base_done, base_frame, bad;
   logic found;

   initial begin
      rst = 1'b1; plot = 1'b1; x = 9'd5; y = 8'd2; color = 3'd3;
      clear_req = 1'b1; clear_color = 3'd4;
      tick(); tick();
      @(negedge clk);
      check_eq("rst_fb_we", fb_we, 0);
      check_eq("rst_fb_addr", fb_addr, 0);
      check_eq("rst_busy", clear_busy, 0);
      check_eq("rst_flags", {clear_done, frame_done, overflow}, 0);
      check_eq("rst_drop", drop_count, 0);
      rst = 1'b0; plot = 1'b0; clear_req = 1'b0;
      tick(); tick(); tick();
      check_eq("rst_ignores_plot", q_wr.size(), 0);
      check_eq("rst_ignores_clear", clear_busy, 0);

      // single plot, 2-cycle latency
      tick();
      base_wr = q_wr.size();
      do_plot(9'd5, 8'd2, 3'd3);
      @(negedge clk);
      check_eq("lat_n1_we", fb_we, 0);
      tick();
      @(negedge clk);
      check_eq("lat_n2_we", fb_we, 1);
      check_eq("lat_n2_addr", fb_addr, 645);
      check_eq("lat_n2_data", fb_data, 3);
      tick();
      @(negedge clk);
      check_eq("lat_n3_we", fb_we, 0);
      tick();
      check_eq("single_pulse", q_wr.size() - base_wr, 1);

      // back-to-back plots keep order
      base_wr = q_wr.size();
      for (int i = 0; i < 3; i++) begin
         plot = 1'b1; x = 9'(1 + i); y = 8'd1; color = 3'(i + 4);
         tick();
      end
      plot = 1'b0;
      repeat (5) tick();
      check_eq("order_count", q_wr.size() - base_wr, 3);
      for (int i = 0; i < 3; i++)
         check_eq($sformatf("order_%0d", i), q_wr[base_wr + i], {17'(321 + i), 3'(i + 4)});
      check_eq("order_no_ovf", overflow, 0);

      // last pixel address raises frame_done
      base_frame = n_frame;
      do_plot(9'd319, 8'd239, 3'd7);
      tick();
      @(negedge clk);
      check_eq("frame_we", fb_we, 1);
      check_eq("frame_addr", fb_addr, 76799);
      check_eq("frame_done", frame_done, 1);
      tick();
      @(negedge clk);
      check_eq("frame_done_off", frame_done, 0);
      tick();
      check_eq("frame_pulses", n_frame - base_frame, 1);

      // off-screen plot
      base_wr = q_wr.size();
      do_plot(9'd320, 8'd0, 3'd5);
      repeat (3) tick();
`ifdef PLOT_BOUNDS_CHECK_EN
      check_eq("oor_no_write", q_wr.size() - base_wr, 0);
      check_eq("oor_drop1", drop_count, 1);
      plot = 1'b1; x = 9'd320; y = 8'd0; color = 3'd5;
      repeat (299) tick();
      plot = 1'b0;
      repeat (4) tick();
      check_eq("oor_drop_sat", drop_count, 255);
      check_eq("oor_no_write_all", q_wr.size() - base_wr, 0);
      check_eq("oor_no_ovf", overflow, 0);
`else
      check_eq("oor_write", q_wr.size() - base_wr, 1);
      check_eq("oor_addr", q_wr[base_wr], {17'd320, 3'd5});
      check_eq("oor_drop0", drop_count, 0);
`endif

      // full clear with plots arriving during CLEAR
      tick();
      base_wr = q_wr.size(); base_busy = n_busy; base_done = n_done; base_frame = n_frame;
      clear_req = 1'b1; clear_color = 3'd6;
      tick();
      clear_req = 1'b0; clear_color = 3'd0;
      for (int i = 0; i < 6; i++) begin
         plot = 1'b1; x = 9'(10 + i); y = 8'd3; color = 3'(i);
         clear_req = (i == 2); clear_color = 3'd2;
         tick();
      end
      plot = 1'b0; clear_req = 1'b0;
      @(negedge clk);
      check_eq("ovf_set", overflow, 1);
      for (int k = 0; k < 80000 && n_done == base_done; k++) tick();
      repeat (10) tick();
      check_eq("clr_done_pulses", n_done - base_done, 1);
      check_eq("clr_busy_cycles", n_busy - base_busy, 76800);
      check_eq("clr_no_frame", n_frame - base_frame, 0);
      check_eq("clr_writes", q_wr.size() - base_wr, 76804);
      bad = 0;
      if (q_wr.size() - base_wr >= 76800) begin
         for (int i = 0; i < 76800; i++)
            if (q_wr[base_wr + i] !== {17'(i), 3'd6}) bad++;
      end else begin
         bad = -1;
      end
      check_eq("clr_bad_writes", bad, 0);
      if (q_wr.size() - base_wr == 76804) begin
         for (int i = 0; i < 4; i++)
            check_eq($sformatf("drain_%0d", i), q_wr[base_wr + 76800 + i], {17'(970 + i), 3'(i)});
      end
      check_eq("ovf_sticky", overflow, 1);

      // reset in the middle of a fill
      clear_req = 1'b1; clear_color = 3'd1;
      tick();
      clear_req = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 2000 && !found; k++) begin
         @(negedge clk);
         if (fb_we && fb_addr == 17'd1000) found = 1'b1;
      end
      check_eq("fill_reached_1000", found, 1);
      rst = 1'b1;
      tick();
      base_wr = q_wr.size(); base_done = n_done;
      @(negedge clk);
      check_eq("abort_we", fb_we, 0);
      check_eq("abort_busy", clear_busy, 0);
      check_eq("abort_ovf_clr", overflow, 0);
      rst = 1'b0;
      repeat (200) tick();
      check_eq("abort_no_done", n_done - base_done, 0);
      check_eq("abort_no_writes", q_wr.size() - base_wr, 0);
      check_eq("frame_with_we", n_frame_bad, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/plot_sink.md
PLOT_SINK -- requirements
Module: plot_sink

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, plot-entry buffer depth (power of two, 2..16).
REQ-002 SHALL have parameter SCREEN_W, default 320, visible width in pixels.
REQ-003 SHALL have parameter SCREEN_H, default 240, visible height in pixels.
REQ-004 SHALL have port clock, input, 1, the single clock; all logic is rising-edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port plot, input, 1, pixel-valid strobe from the map/sprite drawers; sampled every cycle.
REQ-007 SHALL have ports X, Y and color: input, widths 9, 8 and 3, the pixel coordinate and colour, qualified by plot.
REQ-008 SHALL have port clear_req, input, 1, single-cycle request to fill the framebuffer with clear_color.
REQ-009 SHALL have port clear_color, input, 3, fill colour, sampled on the cycle clear_req is accepted.
REQ-010 SHALL have ports fb_we, fb_addr and fb_data: output, widths 1, 17 and 3, a registered framebuffer write port.
REQ-011 SHALL have port clear_busy, output, 1, high while in CLEAR.
REQ-012 SHALL have port clear_done, output, 1, one-cycle pulse when the fill completes.
REQ-013 SHALL have port frame_done, output, 1, one-cycle pulse coincident with the write of the last pixel address.
REQ-014 SHALL have port overflow, output, 1, sticky flag: a plot was lost because the FIFO was full.
REQ-015 SHALL have port drop_count, output, 8, saturating count of out-of-range plots discarded.

Function
REQ-016 SHALL push {X,Y,color} into the FIFO on every cycle where plot=1 and the FIFO is not full; no backpressure exists toward drawers.
REQ-017 SHALL, with plot=1 and the FIFO full, discard the entry and set overflow; push and pop in the same cycle on a full FIFO SHALL accept the push.
REQ-018 SHALL implement states IDLE (FIFO empty), DRAIN (FIFO non-empty, one pop per cycle) and CLEAR.
REQ-019 SHALL register each popped entry into fb_we=1, fb_addr=Y*SCREEN_W+X and fb_data=color, computing the address as (Y<<8)+(Y<<6)+X at 17 bits without a multiplier.
REQ-020 SHALL give plot-to-fb_we latency of exactly 2 cycles when the FIFO is empty and the state is not CLEAR (plot at cycle N, fb_we high at cycle N+2).
REQ-021 SHALL preserve plot order; fb_we SHALL be 0 on every cycle without a pop or clear write.
REQ-022 SHALL pulse frame_done together with fb_we when the plot path writes address SCREEN_W*SCREEN_H-1 (76799).
REQ-023 SHALL accept clear_req in IDLE or DRAIN, enter CLEAR on the next cycle and write clear_color to addresses 0..76799, one per cycle, with the FIFO not popped.
REQ-024 SHALL keep accepting plots into the FIFO during CLEAR, with overflow rules as in REQ-017.
REQ-025 SHALL assert clear_done for the one cycle after the write of address 76799, then go to DRAIN if the FIFO is non-empty, else IDLE.
REQ-026 SHALL ignore clear_req while in CLEAR; frame_done SHALL never pulse from clear writes.

Reset
REQ-027 SHALL, with reset=1 at a clock edge, empty the FIFO and enter IDLE.
REQ-028 SHALL clear fb_we, fb_addr, fb_data, clear_busy, clear_done, frame_done, overflow and drop_count to 0 on that edge.
REQ-029 SHALL abort any fill in progress on reset mid-CLEAR, with no further writes and no clear_done.
REQ-030 SHALL ignore plot and clear_req in the cycle reset is high.

Configuration
REQ-031 SHALL, with PLOT_BOUNDS_CHECK_EN defined, discard popped entries with X>=SCREEN_W or Y>=SCREEN_H: no fb_we, drop_count incremented and saturating at 255.
REQ-032 SHALL, without PLOT_BOUNDS_CHECK_EN, write every popped entry at the computed address truncated to 17 bits, with drop_count held at 0.

Verification
REQ-033 SHALL cover: reset, then plot=1, X=5, Y=2, color=3 for one cycle -> two cycles later fb_we=1, fb_addr=645, fb_data=3, single pulse.
REQ-034 SHALL cover: plot held high for 6 cycles while in CLEAR (FIFO_DEPTH=4) -> first 4 entries retained in order, overflow=1 and stays set after plot drops.
REQ-035 SHALL cover: clear_req with clear_color=6 -> clear_busy high for 76800 cycles, 76800 writes of data 6 at addresses 0..76799, clear_done one pulse, frame_done never high.
REQ-036 SHALL cover: plot X=319, Y=239 -> fb_addr=76799 with frame_done pulse in the same cycle as fb_we.
REQ-037 SHALL cover: with PLOT_BOUNDS_CHECK_EN, plot X=320, Y=0 -> no fb_we and drop_count=1; 300 such plots -> drop_count=255.
REQ-038 SHALL cover: reset asserted at address 1000 of a fill -> next cycle fb_we=0, clear_busy=0, and no clear_done afterward.
